// File: rtl/conv3x3_engine.sv
// 3x3 convolution engine: signed 8-bit kernel, unsigned 8-bit pixels, 3-stage pipeline.
// Build option: define CONV_SATURATE_EN to clamp the shifted result to 0..255
// (otherwise the low 8 bits are kept, wrapping around).
module conv3x3_engine #(
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] pixel1,
  input  logic [7:0] pixel2,
  input  logic [7:0] pixel3,
  input  logic [7:0] pixel4,
  input  logic [7:0] pixel5,
  input  logic [7:0] pixel6,
  input  logic [7:0] pixel7,
  input  logic [7:0] pixel8,
  input  logic [7:0] pixel9,
  input  logic       coef_wr,
  input  logic [3:0] coef_addr,
  input  logic [7:0] coef_data,
  output logic       out_valid,
  output logic [7:0] pixel_out,
  output logic       busy,
  output logic       done
);

  localparam int unsigned NumWin = IMG_W * IMG_H;
  localparam int unsigned CntW   = $clog2(NumWin + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                r_state, w_state_d;
  logic [CntW-1:0]       r_cnt;
  logic signed [7:0]     r_k [9];
  logic [3:0]            r_shift;
  logic [7:0]            w_pix [9];
  logic signed [16:0]    r_prod [9];
  logic signed [20:0]    w_sum, r_sum, w_shifted;
  logic [7:0]            w_fmt;
  logic                  r_v1, r_v2, r_out_valid;
  logic [7:0]            r_pixel_out;
  logic                  w_accept, w_last, w_coef_en, w_cnt_clr;

  assign w_pix[0] = pixel1;
  assign w_pix[1] = pixel2;
  assign w_pix[2] = pixel3;
  assign w_pix[3] = pixel4;
  assign w_pix[4] = pixel5;
  assign w_pix[5] = pixel6;
  assign w_pix[6] = pixel7;
  assign w_pix[7] = pixel8;
  assign w_pix[8] = pixel9;

  assign w_accept  = (r_state == StRun) && in_valid;
  assign w_last    = w_accept && (r_cnt == CntW'(NumWin - 1));
  // Kernel is frozen while a frame is in flight.
  assign w_coef_en = coef_wr && ((r_state == StIdle) || (r_state == StDone));
  assign w_cnt_clr = (w_state_d != r_state) && ((w_state_d == StIdle) || (w_state_d == StRun));

  assign busy      = (r_state == StRun) || (r_state == StDrain);
  assign done      = (r_state == StDone);
  assign out_valid = r_out_valid;
  assign pixel_out = r_pixel_out;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  // Next-state logic; drain ends once only the output stage can still hold data.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (start) w_state_d = StRun;
      StRun:   if (w_last) w_state_d = StDrain;
      StDrain: if (!r_v1 && !r_v2) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Accepted-window counter, cleared on entry to IDLE or RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_cnt <= '0;
    else if (w_cnt_clr) r_cnt <= '0;
    else if (w_accept)  r_cnt <= r_cnt + 1'b1;
  end

  // Coefficient and shift registers; reset to the identity kernel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) r_k[i] <= (i == 4) ? 8'sd1 : 8'sd0;
      r_shift <= '0;
    end else if (w_coef_en) begin
      for (int i = 0; i < 9; i++) begin
        if (coef_addr == 4'(i)) r_k[i] <= signed'(coef_data);
      end
      if (coef_addr == 4'd9) r_shift <= coef_data[3:0];
    end
  end

  // S1: nine signed products of zero-extended pixels and kernel taps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      for (int i = 0; i < 9; i++) r_prod[i] <= '0;
    end else begin
      r_v1 <= w_accept;
      if (w_accept) begin
        for (int i = 0; i < 9; i++) r_prod[i] <= $signed({1'b0, w_pix[i]}) * r_k[i];
      end
    end
  end

  // Lossless 21-bit sum of the sign-extended products.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 9; i++) w_sum = w_sum + {{4{r_prod[i][16]}}, r_prod[i]};
  end

  // S2: register the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2  <= 1'b0;
      r_sum <= '0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) r_sum <= w_sum;
    end
  end

  // Arithmetic shift and 8-bit output formatting.
  always_comb begin
    w_shifted = r_sum >>> r_shift;
`ifdef CONV_SATURATE_EN
    if (w_shifted < 21'sd0)        w_fmt = 8'd0;
    else if (w_shifted > 21'sd255) w_fmt = 8'd255;
    else                           w_fmt = w_shifted[7:0];
`else
    w_fmt = w_shifted[7:0];
`endif
  end

  // S3: output register; pixel_out is held at zero whenever out_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_pixel_out <= '0;
    end else begin
      r_out_valid <= r_v2;
      r_pixel_out <= r_v2 ? w_fmt : 8'd0;
    end
  end

endmodule

// File: tb/tb_conv3x3_engine.sv
// Directed bench for conv3x3_engine (default 64x64 frame).
module tb_conv3x3_engine;

  logic       clk = 1'b0;
  logic       rst_n, start, in_valid, coef_wr;
  logic [7:0] p [9];
  logic [3:0] coef_addr;
  logic [7:0] coef_data;
  logic       out_valid, busy, done;
  logic [7:0] pixel_out;

  conv3x3_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .pixel1    (p[0]),
    .pixel2    (p[1]),
    .pixel3    (p[2]),
    .pixel4    (p[3]),
    .pixel5    (p[4]),
    .pixel6    (p[5]),
    .pixel7    (p[6]),
    .pixel8    (p[7]),
    .pixel9    (p[8]),
    .coef_wr   (coef_wr),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_valid (out_valid),
    .pixel_out (pixel_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_total = 0, n_bad = 0;
  int   cyc = 0, out_cnt = 0, done_cnt = 0, last_out_cyc = -100;

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: value, exact latency, ordering, and done timing.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk_eq("spurious_ov", int'(out_valid), 0);
        end else begin
          m_e = q.pop_front();
          chk_eq("pix", int'(pixel_out), m_e.val);
          chk_eq("lat", cyc, m_e.cyc);
        end
        last_out_cyc = cyc;
        out_cnt++;
      end else begin
        chk_eq("pix_idle_zero", int'(pixel_out), 0);
      end
      if (done) begin
        done_cnt++;
        chk_eq("done_lat", cyc, last_out_cyc + 1);
        chk_eq("done_q_empty", q.size(), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_coef(input logic [3:0] a, input logic [7:0] d);
    coef_wr = 1'b1; coef_addr = a; coef_data = d;
    tick();
    coef_wr = 1'b0;
  endtask

  task automatic set_all_k(input logic [7:0] d);
    for (int i = 0; i < 9; i++) wr_coef(4'(i), d);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Window pattern per mode, with its hand-computed result.
  task automatic set_win(input int mode, input int i, output int e);
    case (mode)
      0: begin
        if (i == 0) begin
          for (int j = 0; j < 9; j++) p[j] = 8'(j + 1);
          e = 5;
        end else begin
          for (int j = 0; j < 9; j++) p[j] = 8'hAA;
          p[4] = 8'(i % 256);
          e = i % 256;
        end
      end
      1: begin
        for (int j = 0; j < 9; j++) p[j] = 8'd16;
        e = 18;
      end
      2: begin
        for (int j = 0; j < 9; j++) p[j] = 8'h37;
        p[4] = 8'd10;
`ifdef CONV_SATURATE_EN
        e = 0;
`else
        e = 246;
`endif
      end
      3: begin
        for (int j = 0; j < 9; j++) p[j] = 8'd255;
`ifdef CONV_SATURATE_EN
        e = 255;
`else
        e = 184;
`endif
      end
      default: begin
        for (int j = 0; j < 9; j++) p[j] = 8'h55;
        p[4] = 8'(i % 128);
        e = 2 * (i % 128);
      end
    endcase
  endtask

  // Streams n back-to-back windows; poke tries a k5 write and a start mid-frame.
  task automatic run_frame(input string tag, input int mode, input int n, input bit poke);
    int   o0, d0, e;
    exp_t x;
    o0 = out_cnt;
    d0 = done_cnt;
    for (int i = 0; i < n; i++) begin
      set_win(mode, i, e);
      in_valid = 1'b1;
      x.val = e;
      x.cyc = cyc + 3;
      q.push_back(x);
      if (poke && i == 50) begin
        coef_wr = 1'b1; coef_addr = 4'd4; coef_data = 8'd2; start = 1'b1;
      end
      if (i == 10) chk_eq({tag, "_busy_mid"}, int'(busy), 1);
      tick();
      coef_wr = 1'b0;
      start   = 1'b0;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 20 && done_cnt == d0; k++) begin
      @(negedge clk);
      #1;
    end
    chk_eq({tag, "_done_seen"}, done_cnt - d0, 1);
    chk_eq({tag, "_outs"}, out_cnt - o0, n);
    @(negedge clk);
    #1;
    chk_eq({tag, "_busy_after"}, int'(busy), 0);
    chk_eq({tag, "_done_after"}, int'(done), 0);
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int o0, d0, e;
    exp_t x;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; coef_wr = 1'b0;
    coef_addr = '0; coef_data = '0;
    for (int j = 0; j < 9; j++) p[j] = '0;
    #12;
    chk_eq("rst_out_valid", int'(out_valid), 0);
    chk_eq("rst_pixel_out", int'(pixel_out), 0);
    chk_eq("rst_busy", int'(busy), 0);
    chk_eq("rst_done", int'(done), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_eq("idle_busy", int'(busy), 0);

    // Identity kernel from reset; mid-frame k5 write and start must be ignored.
    do_start();
    run_frame("ident", 0, 4096, 1'b1);

    // All-ones kernel, shift 3.
    set_all_k(8'd1);
    wr_coef(4'd9, 8'd3);
    wr_coef(4'd12, 8'd7);  // unmapped address, no effect
    do_start();
    run_frame("box", 1, 4096, 1'b0);

    // k5 = -1, shift 0: negative result.
    set_all_k(8'd0);
    wr_coef(4'd4, 8'hFF);
    wr_coef(4'd9, 8'd0);
    do_start();
    run_frame("neg", 2, 4096, 1'b0);

    // All taps 8 on white: overflow above 255.
    set_all_k(8'd8);
    do_start();
    run_frame("ovf", 3, 4096, 1'b0);

    // Reset after 100 windows: nothing may follow.
    do_start();
    for (int i = 0; i < 100; i++) begin
      set_win(3, i, e);
      in_valid = 1'b1;
      x.val = e;
      x.cyc = cyc + 3;
      q.push_back(x);
      tick();
    end
    #2;
    rst_n = 1'b0;
    q.delete();
    in_valid = 1'b0;
    o0 = out_cnt;
    d0 = done_cnt;
    #1;
    chk_eq("midrst_out_valid", int'(out_valid), 0);
    chk_eq("midrst_pixel_out", int'(pixel_out), 0);
    chk_eq("midrst_busy", int'(busy), 0);
    tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk_eq("midrst_no_out", out_cnt - o0, 0);
    chk_eq("midrst_no_done", done_cnt - d0, 0);

    // Coefficients are back to identity; busy-time write still dropped.
    do_start();
    run_frame("ident2", 0, 4096, 1'b1);

    // Write k5 = 2 in the same IDLE cycle as start: frame uses the new value.
    coef_wr = 1'b1; coef_addr = 4'd4; coef_data = 8'd2; start = 1'b1;
    tick();
    coef_wr = 1'b0; start = 1'b0;
    run_frame("dbl", 4, 4096, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
